// File: rtl/mux4_scan_sampler.sv
// Scans a 4:1 mux select through channels 0..3, samples z0 after a settle interval and
// publishes the packed word with a one-cycle valid strobe. Macro MUX4_SCAN_CHANGE_EN adds 'changed'.
module mux4_scan_sampler #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          CONTINUOUS    = 1'b0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic       z0,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] data,
  output logic       valid
`ifdef MUX4_SCAN_CHANGE_EN
  ,
  output logic       changed
`endif
);

  localparam int CW = (SETTLE_CYCLES > 32'd1) ? $clog2(SETTLE_CYCLES + 32'd1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  generate
    if ((SETTLE_CYCLES < 32'd1) || (SETTLE_CYCLES > 32'd255)) begin : g_bad_settle
      $error("mux4_scan_sampler: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    sel_r, sel_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    shadow_r, shadow_s;
  logic          busy_r, busy_s;
  logic          valid_r, valid_s;
  logic [3:0]    data_r, data_s;
  logic          restart_s;
`ifdef MUX4_SCAN_CHANGE_EN
  logic          changed_r, changed_s;
`endif

  // State register plus all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      sel_r     <= 2'd0;
      cnt_r     <= '0;
      shadow_r  <= 4'd0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      data_r    <= 4'd0;
`ifdef MUX4_SCAN_CHANGE_EN
      changed_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      cnt_r     <= cnt_s;
      shadow_r  <= shadow_s;
      busy_r    <= busy_s;
      valid_r   <= valid_s;
      data_r    <= data_s;
`ifdef MUX4_SCAN_CHANGE_EN
      changed_r <= changed_s;
`endif
    end
  end

  // Next-state logic; abort always wins over start and over the SAMPLE capture
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    cnt_s     = cnt_r;
    shadow_s  = shadow_r;
    restart_s = (start | CONTINUOUS) & ~abort;
    case (state_r)
      ST_IDLE: begin
        sel_s = 2'd0;
        cnt_s = '0;
        if (start && !abort) begin
          state_s  = ST_SETTLE;
          shadow_s = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_s = ST_IDLE;
          sel_s   = 2'd0;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_s = ST_IDLE;
          sel_s   = 2'd0;
          cnt_s   = '0;
        end else begin
          shadow_s[sel_r] = z0;
          if (sel_r != 2'd3) begin
            state_s = ST_SETTLE;
            sel_s   = sel_r + 2'd1;
            cnt_s   = '0;
          end else begin
            state_s = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        sel_s = 2'd0;
        cnt_s = '0;
        if (restart_s) begin
          state_s  = ST_SETTLE;
          shadow_s = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sel_s   = 2'd0;
        cnt_s   = '0;
      end
    endcase
  end

  // Output logic; the word is published on the cycle after DONE so every output stays registered
  always_comb begin
    busy_s = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
`ifdef MUX4_SCAN_CHANGE_EN
    changed_s = 1'b0;
`endif
    if (state_r == ST_DONE) begin
      valid_s = 1'b1;
      data_s  = shadow_r;
`ifdef MUX4_SCAN_CHANGE_EN
      changed_s = (shadow_r != data_r);
`endif
    end else begin
      valid_s = 1'b0;
      data_s  = data_r;
    end
  end

  assign s1    = sel_r[1];
  assign s0    = sel_r[0];
  assign busy  = busy_r;
  assign valid = valid_r;
  assign data  = data_r;
`ifdef MUX4_SCAN_CHANGE_EN
  assign changed = changed_r;
`endif

endmodule

// File: tb/tb_mux4_scan_sampler.sv
// Randomized self-checking bench for mux4_scan_sampler: a mux model drives z0 and a
// per-edge history of d predicts every published word, strobe, select and busy value.
module tb_mux4_scan_sampler;
  localparam int S   = 4;
  localparam int CH  = S + 1;
  localparam int PER = 4 * CH + 1;

  logic       clk = 1'b0;
  logic       rstn, start, abort, z0;
  logic       s1, s0, busy, valid;
  logic [3:0] data;
  logic [3:0] d;
`ifdef MUX4_SCAN_CHANGE_EN
  logic       changed;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] prev_word;
  logic [3:0] dv_at [0:255];

  mux4_scan_sampler #(.SETTLE_CYCLES(S), .CONTINUOUS(1'b0)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .abort (abort),
    .z0    (z0),
    .s1    (s1),
    .s0    (s0),
    .busy  (busy),
    .data  (data),
    .valid (valid)
`ifdef MUX4_SCAN_CHANGE_EN
    ,
    .changed (changed)
`endif
  );

  assign z0 = d[{s1, s0}];
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // bit i is whatever d held on the edge that closes channel i of the scan accepted at edge 'base'
  function automatic logic [3:0] model_word(input int base);
    logic [3:0] w;
    for (int i = 0; i < 4; i++) w[i] = dv_at[base + (i + 1) * CH][i];
    return w;
  endfunction

  task automatic check_publish(input logic ev);
    logic [3:0] w;
    check_eq("valid", 32'(valid), 32'(ev));
`ifdef MUX4_SCAN_CHANGE_EN
    if (!ev) check_eq("changed_idle", 32'(changed), 32'd0);
`endif
    if (ev) begin
      w = model_word(0);
`ifdef MUX4_SCAN_CHANGE_EN
      check_eq("changed", 32'(changed), 32'(w != prev_word));
`endif
      prev_word = w;
    end
  endtask

  // nscans back-to-back scans (start held between them); d switches to dv_b from edge chg on
  task automatic run_scans(input int nscans, input logic [3:0] dv_a, input logic [3:0] dv_b,
                           input int chg);
    int lat, pos, base;
    logic [3:0] w;
    d = dv_a; start = 1'b1; abort = 1'b0; dv_at[0] = dv_a;
    for (int k = 1; k <= nscans * PER + 4; k++) begin
      @(negedge clk);
      lat = k - 1;
      if (lat > 0 && lat % PER == 0) begin
        check_eq("valid", 32'(valid), 32'd1);
        base = (lat / PER - 1) * PER;
        w = model_word(base);
`ifdef MUX4_SCAN_CHANGE_EN
        check_eq("changed", 32'(changed), 32'(w != prev_word));
`endif
        prev_word = w;
      end else begin
        check_eq("valid_low", 32'(valid), 32'd0);
      end
      check_eq("data", 32'(data), 32'(prev_word));
      if (lat < nscans * PER) begin
        pos = lat % PER;
        if (pos < 4 * CH) begin
          check_eq("busy_scan", 32'(busy), 32'd1);
          check_eq("sel_scan", 32'({s1, s0}), 32'(pos / CH));
        end else begin
          check_eq("busy_done", 32'(busy), 32'd0);
        end
      end else begin
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("sel_idle", 32'({s1, s0}), 32'd0);
      end
      d = (k >= chg) ? dv_b : dv_a;
      dv_at[k] = d;
      start = (k <= (nscans - 1) * PER);
    end
    start = 1'b0;
  endtask

  // abort seen on edge ka (1..20 hits SETTLE/SAMPLE, PER hits DONE); hold keeps start high up to ka
  task automatic run_abort(input logic [3:0] dv, input int ka, input bit hold);
    int lat, busy_end;
    busy_end = (ka < 4 * CH) ? ka : 4 * CH;
    d = dv; start = 1'b1; abort = 1'b0;
    for (int k = 0; k < 256; k++) dv_at[k] = dv;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      lat = k - 1;
      check_publish((ka == PER) && (lat == PER));
      check_eq("abort_data", 32'(data), 32'(prev_word));
      if (lat < busy_end) begin
        check_eq("abort_busy", 32'(busy), 32'd1);
        check_eq("abort_sel", 32'({s1, s0}), 32'(lat / CH));
      end else if (lat == 4 * CH && ka == PER) begin
        check_eq("abort_busy_done", 32'(busy), 32'd0);
      end else begin
        check_eq("abort_busy_idle", 32'(busy), 32'd0);
        check_eq("abort_sel_idle", 32'({s1, s0}), 32'd0);
      end
      abort = (k == ka);
      start = hold && (k <= ka);
    end
    abort = 1'b0; start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, 32'({busy, valid, s1, s0, data}), 32'd0);
`ifdef MUX4_SCAN_CHANGE_EN
    check_eq("rst_changed", 32'(changed), 32'd0);
`endif
  endtask

  initial begin
    logic [3:0] order [16];
    logic [3:0] tmp;
    int j;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; d = 4'd0; prev_word = 4'd0;
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_release");

    // directed pattern 1010, single start pulse
    run_scans(1, 4'b1010, 4'b1010, 999);

    // all 16 input words, in random order
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 16; i++) run_scans(1, order[i], order[i], 999);

    // back-to-back with d switching after channel 1 was captured
    run_scans(2, 4'b0011, 4'b1100, $urandom_range(15, 11));
    for (int i = 0; i < 4; i++)
      run_scans($urandom_range(3, 1), 4'($urandom), 4'($urandom), $urandom_range(60, 1));

    // abort during channel 2 settle, then random abort points including DONE
    run_scans(1, 4'b0101, 4'b0101, 999);
    run_abort(4'($urandom), $urandom_range(14, 11), 1'b0);
    check_eq("abort_keeps_0101", 32'(data), 32'd5);
    for (int i = 0; i < 6; i++) begin
      run_abort(4'($urandom), $urandom_range(PER, 1), 1'($urandom_range(1, 0)));
      run_scans(1, 4'($urandom), 4'($urandom), $urandom_range(25, 1));
    end

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("idle_abort_wins", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("idle_abort_sel", 32'({s1, s0}), 32'd0);

    // asynchronous reset mid-scan, start pulses during reset
    d = 4'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(15, 3)) @(negedge clk);
    #3 rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    prev_word = 4'd0;
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    start = 1'b0;
    #2 rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_release");
    run_scans(1, 4'($urandom), 4'($urandom), 999);

    // change-detect sequence
    run_scans(1, 4'b0000, 4'b0000, 999);
    run_scans(1, 4'b0000, 4'b0000, 999);
    run_scans(1, 4'b0110, 4'b0110, 999);
    check_eq("final_word", 32'(data), 32'h6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
